// File: rtl/plic_gateway_if.sv
// rtl/plic_gateway_if.sv - claim/complete strobes and per-source status between PLIC core and gateway
interface plic_gateway_if #(
    parameter int SRC_N = 31
);
    logic             claim_valid;
    logic [4:0]       claim_id;
    logic             complete_valid;
    logic [4:0]       complete_id;
    logic [SRC_N-1:0] pending;
    logic [SRC_N-1:0] busy;
    logic [SRC_N-1:0] ovf;

    modport master (
        output claim_valid, claim_id, complete_valid, complete_id,
        input  pending, busy, ovf
    );

    modport slave (
        input  claim_valid, claim_id, complete_valid, complete_id,
        output pending, busy, ovf
    );
endinterface

// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - per-source interrupt gateway: sync, level/edge capture, claim/complete gating
module plic_gateway #(
    parameter int SRC_N  = 31,
    parameter int CNT_W  = 4,
    parameter int SYNC_S = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SRC_N-1:0] int_src,
    input  logic [SRC_N-1:0] edge_mode,
    plic_gateway_if.slave    gw
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [SRC_N-1:0] src_s;
    logic [SRC_N-1:0] src_q;
    logic [SRC_N-1:0] mode_q;
    logic [SRC_N-1:0] busy_q;
    logic [SRC_N-1:0] ovf_q;
    logic [CNT_W-1:0] cnt [SRC_N];

    logic [SRC_N-1:0] rise;
    logic [SRC_N-1:0] pend;
    logic [SRC_N-1:0] claim_hit;
    logic [SRC_N-1:0] complete_hit;

    generate
        if (SYNC_S == 0) begin : g_nosync
            assign src_s = int_src;
        end else begin : g_sync
            logic [SRC_N-1:0] sync_q [SYNC_S];

            // Shift raw sources through the synchroniser chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SYNC_S; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q[0] <= int_src;
                    for (int s = 1; s < SYNC_S; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign src_s = sync_q[SYNC_S-1];
        end
    endgenerate

    // Pending is built only from registered state; the mode is registered so
    // that edge_mode has no direct path to pending.
    always_comb begin
        rise         = src_s & ~src_q;
        pend         = '0;
        claim_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < SRC_N; i++) begin
            pend[i]         = (mode_q[i] ? (cnt[i] != '0) : src_q[i]) & ~busy_q[i];
            claim_hit[i]    = gw.claim_valid && (gw.claim_id == 5'(i + 1)) && pend[i];
            complete_hit[i] = gw.complete_valid && (gw.complete_id == 5'(i + 1)) && busy_q[i];
        end
    end

    // Delayed source copy, registered mode, and the claim/complete busy flags
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            mode_q <= '0;
            busy_q <= '0;
        end else begin
            src_q  <= src_s;
            mode_q <= edge_mode;
            for (int i = 0; i < SRC_N; i++) begin
                if (claim_hit[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (complete_hit[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating edge counters; a rise and a take in the same cycle cancel.
    // The cnt != 0 guard covers a level-pending claim in the cycle the mode flips to edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SRC_N; i++) begin
                cnt[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < SRC_N; i++) begin
                ovf_q[i] <= 1'b0;
                if (!edge_mode[i]) begin
                    cnt[i] <= '0;
                end else if (rise[i] && !claim_hit[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf_q[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end else if (claim_hit[i] && !rise[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    assign gw.pending = pend;
    assign gw.busy    = busy_q;
    assign gw.ovf     = ovf_q;

endmodule

// File: doc/plic_gateway.md
# plic_gateway

Parametrised per-source interrupt gateway for the PLIC, placed between raw interrupt source wires and the PLIC priority/arbitration core. It synchronises each source and supports level or edge mode per source. Edge mode uses a saturating pending counter, so bursts are not lost. It also implements the claim/complete handshake that gates re-presentation of a source while its handler is in flight. Source IDs are 1..SRC_N. ID 0 is reserved and means "no interrupt".

## Interface
Parameters:
- SRC_N, 31, number of sources (1..31); source ID i+1 maps to bit i.
- CNT_W, 4, edge-pending counter width; saturates at 2^CNT_W-1.
- SYNC_S, 2, input synchroniser depth (0..3); 0 means int_src is already synchronous to clk.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- int_src  in  SRC_N  raw interrupt sources.
- edge_mode  in  SRC_N  per-source mode: 1 = rising-edge, 0 = level-high.
- claim_valid  in  1  one-cycle claim strobe from the PLIC core.
- claim_id  in  5  ID being claimed.
- complete_valid  in  1  one-cycle completion strobe (APB complete write).
- complete_id  in  5  ID being completed.
- pending  out  SRC_N  per-source pending, presented to the arbiter.
- busy  out  SRC_N  per-source in-flight flag (claimed, not yet completed).
- ovf  out  SRC_N  one-cycle pulse when an edge arrives while that source's counter is saturated.

## Operation
- Per-source state:
  - sync chain sync[SYNC_S]
  - delayed copy src_q
  - counter cnt[CNT_W]
  - busy flag
  - src_s is the last sync flop, or int_src when SYNC_S=0.
- Edge mode:
  - Rising edge is rise = src_s & ~src_q.
  - cnt_next = cnt + rise - take, where take = accepted claim of this ID.
  - If rise occurs at cnt = max with no take, cnt holds and ovf pulses.
  - pending = (cnt != 0) & ~busy.
- Level mode:
  - pending = src_q & ~busy.
  - cnt is forced to 0 every cycle while edge_mode=0, so switching modes drops stored edges.
- Claim rules:
  - A claim is accepted only if claim_valid, 1 <= claim_id <= SRC_N, and pending[claim_id-1] = 1.
  - On acceptance, busy is set next cycle; in edge mode cnt also decrements by one.
  - Claims that are not accepted cause no state change.
- Complete rules:
  - A complete is accepted if complete_valid, the ID is in range, and busy = 1.
  - On acceptance, busy clears next cycle. Other completes are ignored.
- Both strobes may fire in the same cycle for different IDs; each is handled independently.
- Same ID in the same cycle: the claim is necessarily rejected because busy masks pending, and the complete clears busy.
- Simultaneous rise and accepted claim on the same source: cnt is unchanged, busy is set.
- In edge mode, a source with cnt > 1 re-presents pending in the cycle after busy clears.
- In level mode, a source still high after complete re-presents pending in the cycle after busy clears.
- pending and busy are combinational from registers only (no input-to-output path); ovf is registered.

## Timing
- Reset (rst high at a clock edge) clears all sync flops, src_q, cnt, busy, and ovf. Next cycle: pending=0, busy=0, ovf=0.
- Reset mid-operation discards in-flight claims and stored edges. A level source still high re-pends SYNC_S+1 edges after rst deasserts.
- Source latency: int_src goes high before edge k.
  - src_s is high after edge k+SYNC_S-1.
  - src_q, and the cnt increment, update at edge k+SYNC_S.
  - pending is visible after edge k+SYNC_S, i.e. SYNC_S+1 edges.
- Claim or complete latency: the strobe at edge k takes effect in state after edge k; pending reflects it in cycle k+1.
- Edge pulses narrower than one clk period may be missed. Requirement on sources: pulses of at least 1 cycle (SYNC_S=0) or 2 cycles (SYNC_S>0).
- No backpressure: strobes are single-cycle and always sampled.

## Test plan
- Reset: hold int_src=all-ones in level mode with rst high -> pending=0, busy=0, ovf=0. Release rst (SYNC_S=2) -> pending=all-ones exactly 3 edges later.
- Level claim/complete: src 3 high, claim_id=3 -> busy[2]=1 and pending[2]=0 next cycle. Complete_id=3 while src still high -> pending[2]=1 the cycle after busy clears. Drop src first instead -> pending stays 0.
- Edge burst (CNT_W=4): 5 separate pulses on src 1 -> cnt=5. Five claim/complete pairs each assert pending again; the sixth sees pending=0.
- Saturation: 17 pulses on src 2 with no claims -> cnt=15, ovf[1] pulses once on the 16th and 17th edges (one pulse each).
- Invalid ops: claim_id=0, claim_id=SRC_N+1, claim of a non-pending ID, complete of a non-busy ID -> no change in pending or busy.
- Simultaneous events: rise on src 4 in the same cycle as an accepted claim of 4 with cnt=1 -> cnt stays 1, busy[3]=1. Claim 5 and complete 6 in the same cycle -> busy[4] set and busy[5] cleared together.
